// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package seg_pkg;

  // Register map
  localparam logic ADDR_VALUE = 1'b0;
  localparam logic ADDR_CTRL  = 1'b1;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_LZB_BIT  = 1;
  localparam int unsigned CTRL_MASK_LSB = 2;
  localparam int unsigned CTRL_MASK_MSB = 5;

  // Enabled, leading-zero blank off, all four digits shown
  localparam logic [5:0] CTRL_RESET = 6'b111101;

  localparam logic [6:0] BLANK_SEG = 7'b0000000;

  // Scan FSM state encoding
  typedef logic [1:0] seg_state_t;
  localparam seg_state_t IDLE = 2'd0;
  localparam seg_state_t SHOW = 2'd1;
  localparam seg_state_t GAP  = 2'd2;

  typedef struct packed {
    logic [3:0] mask;
    logic       lzb;
    logic       enable;
  } seg_ctrl_t;

  // True when nibbles idx..3 of value are all zero; digit 0 never qualifies.
  function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] idx);
    logic z;
    z = 1'b0;
    case (idx)
      2'd3:    z = (value[15:12] == 4'h0);
      2'd2:    z = (value[15:8] == 8'h00);
      2'd1:    z = (value[15:4] == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Digit index to active-high one-hot select; index 3 is the leftmost digit.
  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU store-path write bus into the scan controller registers.
interface seg_scan_ctrl_if;
  logic        wr_en;
  logic        wr_addr;
  logic [15:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input wr_en, input wr_addr, input wr_data);
endinterface

// File: rtl/hex2seg.sv
// Hex nibble to active-high 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex2seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup of the segment pattern
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Frame-synchronised 4-digit 7-segment scan controller with anti-ghosting blank gap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus,
  output logic [3:0]     sel,
  output logic [6:0]     leds,
  output logic           frame_tick
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : gen_param_check
    $error("seg_scan_ctrl: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIV");
  end

  seg_ctrl_t        ctrl_q, ctrl_d;
  logic [15:0]      value_q, value_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  seg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       sel_q, sel_d;
  logic [6:0]       leds_q, leds_d;
  logic             frame_tick_q;

  logic             value_wr, ctrl_wr, load_shadow;
  logic [3:0]       nibble;
  logic [6:0]       seg_pat;
  logic             digit_on;

  // Upper write-data bits have no CTRL meaning
  logic             unused_wr_data;
  assign unused_wr_data = ^bus.wr_data[15:6];

  // Register write decode; CTRL takes effect on the cycle after the strobe
  always_comb begin
    value_wr = bus.wr_en && (bus.wr_addr == ADDR_VALUE);
    ctrl_wr  = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
    value_d  = value_wr ? bus.wr_data : value_q;
    ctrl_d   = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.mask   = bus.wr_data[CTRL_MASK_MSB:CTRL_MASK_LSB];
      ctrl_d.lzb    = bus.wr_data[CTRL_LZB_BIT];
      ctrl_d.enable = bus.wr_data[CTRL_EN_BIT];
    end
  end

  // Slot scheduler: SHOW for DIV-BLANK_CYCLES cycles, GAP for BLANK_CYCLES, digit 3 first
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    load_shadow = 1'b0;
    if (!ctrl_q.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SHOW;
          cnt_d       = '0;
          idx_d       = 2'd3;
          load_shadow = 1'b1;
        end
        SHOW: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHOW_LAST) begin
            state_d = GAP;
          end
        end
        GAP: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            idx_d   = idx_q - 2'd1;
            if (idx_q == 2'd0) begin
              wrap_d      = 1'b1;
              // A write landing on the wrap cycle is picked up via value_d
              load_shadow = pending_q || value_wr;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Shadow only updates at a frame boundary so a frame never tears
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (value_wr) begin
      pending_d = 1'b1;
    end
    if (load_shadow) begin
      shadow_d  = value_d;
      pending_d = 1'b0;
    end
  end

  // Select the nibble of the current digit for the shared decoder
  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      2'd0:    nibble = shadow_q[3:0];
      2'd1:    nibble = shadow_q[7:4];
      2'd2:    nibble = shadow_q[11:8];
      default: nibble = shadow_q[15:12];
    endcase
  end

  hex2seg u_hex2seg (
    .hex (nibble),
    .seg (seg_pat)
  );

  // Suppressed digits keep their slot timing but stay dark
  always_comb begin
    digit_on = (state_q == SHOW) && ctrl_q.mask[idx_q] &&
               !(ctrl_q.lzb && lead_zero(shadow_q, idx_q));
    sel_d    = digit_on ? digit_onehot(idx_q) : 4'b0000;
    leds_d   = digit_on ? seg_pat : BLANK_SEG;
  end

  // All state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= seg_ctrl_t'(CTRL_RESET);
      value_q      <= 16'h0000;
      shadow_q     <= 16'h0000;
      pending_q    <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      wrap_q       <= 1'b0;
      sel_q        <= 4'b0000;
      leds_q       <= BLANK_SEG;
      frame_tick_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      value_q      <= value_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      sel_q        <= sel_d;
      leds_q       <= leds_d;
      // Lines up with the first lit cycle of digit 3 in the new frame
      frame_tick_q <= wrap_q;
    end
  end

  assign sel        = sel_q;
  assign leds       = leds_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=16, BLANK_CYCLES=4.
module tb_seg_scan_ctrl;

  localparam int unsigned CLK_HZ  = 16000;
  localparam int unsigned SCAN_HZ = 1000;
  localparam int unsigned BLANK   = 4;
  localparam int SLOT = 16;
  localparam int ON   = 12;

  logic       clk;
  logic       rst_n;
  logic [3:0] sel;
  logic [6:0] leds;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sel        (sel),
    .leds       (leds),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " sel"}, {28'd0, sel}, 32'd0);
    chk({tag, " leds"}, {25'd0, leds}, 32'd0);
    chk({tag, " tick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  task automatic bus_write(input logic addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Check frame cycles k0..k1-1, starting at cycle k0 of a frame (k=0 is digit 3's first lit cycle)
  task automatic check_span(input logic [15:0] val, input logic [3:0] show,
                            input int k0, input int k1, input bit tick0);
    int         digit;
    int         kk;
    logic       on;
    logic [3:0] exp_sel;
    logic [6:0] exp_leds;
    for (int k = k0; k < k1; k++) begin
      digit    = 3 - (k / SLOT);
      kk       = k % SLOT;
      on       = show[digit] && (kk < ON);
      exp_sel  = on ? (4'b0001 << digit) : 4'b0000;
      exp_leds = on ? seg_of(val[digit*4 +: 4]) : 7'h00;
      chk($sformatf("sel v=%h k=%0d", val, k), {28'd0, sel}, {28'd0, exp_sel});
      chk($sformatf("leds v=%h k=%0d", val, k), {25'd0, leds}, {25'd0, exp_leds});
      if (k != 0 || tick0) begin
        chk($sformatf("tick v=%h k=%0d", val, k), {31'd0, frame_tick}, (k == 0) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick seen", {31'd0, frame_tick}, 32'd1);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 1'b0;
    bus.wr_data = 16'h0000;
    rst_n       = 1'b1;
    #2 rst_n    = 1'b0;

    // Reset state
    @(negedge clk);
    chk_dark("reset");
    @(negedge clk);
    chk_dark("reset hold");
    rst_n = 1'b1;

    // First edge enters SHOW; digit 3 lit from the second edge
    @(negedge clk);
    chk_dark("post-release c1");
    @(negedge clk);
    check_span(16'h0000, 4'b1111, 0, 64, 1'b0);

    // Basic scan of 12AF with frame_tick every 64 cycles
    bus_write(1'b0, 16'h12AF);
    wait_tick(200);
    check_span(16'h12AF, 4'b1111, 0, 64, 1'b1);
    check_span(16'h12AF, 4'b1111, 0, 20, 1'b1);

    // Mid-frame writes during digit 2 must not tear the current frame
    bus_write(1'b0, 16'h0000);
    bus_write(1'b0, 16'h1234);
    check_span(16'h12AF, 4'b1111, 22, 64, 1'b1);
    check_span(16'h1234, 4'b1111, 0, 64, 1'b1);

    // Leading-zero blanking
    bus_write(1'b1, 16'h003F);
    bus_write(1'b0, 16'h0070);
    wait_tick(200);
    check_span(16'h0070, 4'b0011, 0, 64, 1'b1);
    bus_write(1'b0, 16'h0000);
    wait_tick(200);
    check_span(16'h0000, 4'b0001, 0, 64, 1'b1);

    // Digit mask 0101, lzb off; upper write-data bits set and ignored
    bus_write(1'b1, 16'hFFC0 | 16'h0015);
    bus_write(1'b0, 16'hABCD);
    wait_tick(200);
    check_span(16'hABCD, 4'b0101, 0, 64, 1'b1);

    // Disable mid-SHOW of digit 3; outputs go dark two cycles after the write
    bus_write(1'b1, 16'h003D);
    bus_write(1'b0, 16'h5678);
    bus_write(1'b1, 16'h003C);
    chk("disable +1 sel", {28'd0, sel}, 32'h8);
    chk("disable +1 leds", {25'd0, leds}, {25'd0, seg_of(4'hA)});
    @(negedge clk);
    chk("disable +2 sel", {28'd0, sel}, 32'h8);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk_dark($sformatf("disabled %0d", i));
      @(negedge clk);
    end

    // Re-enable reloads shadow and restarts at digit 3
    bus_write(1'b1, 16'h003D);
    chk_dark("reenable +1");
    @(negedge clk);
    chk_dark("reenable +2");
    @(negedge clk);
    check_span(16'h5678, 4'b1111, 0, 64, 1'b0);
    check_span(16'h5678, 4'b1111, 0, 16, 1'b1);

    // Dirty the registers, then reset during digit 2's GAP
    bus_write(1'b1, 16'h0017);
    bus_write(1'b0, 16'h9999);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_dark("gap reset async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_dark($sformatf("gap reset hold %0d", i));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_dark("gap reset release c1");
    @(negedge clk);
    check_span(16'h0000, 4'b1111, 0, 64, 1'b0);

    // Reset while a digit is lit clears outputs without a clock edge
    check_span(16'h0000, 4'b1111, 0, 4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("show reset async sel", {28'd0, sel}, 32'd0);
    chk("show reset async leds", {25'd0, leds}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
